// File: rtl/sdram_fifo_tester.sv
// Host-side traffic generator/checker for the SDRAM controller FIFO ports.
// Writes an XOR-keyed index pattern, waits for drain, reads back and checks it.
module sdram_fifo_tester #(
    parameter int               DSIZE      = 16,
    parameter int               ASIZE      = 23,
    parameter int               WORDS      = 1024,
    parameter int               BURST      = 256,
    parameter int               START_ADDR = 0,
    parameter logic [DSIZE-1:0] PATTERN    = 16'hA5C3,
    parameter int               CLR_CYC    = 4,
    parameter int               DRAIN_CYC  = 64,
    parameter int               WDOG       = 65535
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    output logic             WR,
    output logic [DSIZE-1:0] WR_DATA,
    input  logic             WR_FULL,
    input  logic [15:0]      WR_USE,
    output logic             WR_LOAD,
    output logic             RD,
    input  logic [DSIZE-1:0] RD_DATA,
    input  logic             RD_EMPTY,
    output logic             RD_LOAD,
    output logic [ASIZE-1:0] WR_ADDR,
    output logic [ASIZE-1:0] RD_ADDR,
    output logic [ASIZE-1:0] WR_MAX_ADDR,
    output logic [ASIZE-1:0] RD_MAX_ADDR,
    output logic [8:0]       WR_LENGTH,
    output logic [8:0]       RD_LENGTH,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             TIMEOUT,
    output logic [15:0]      ERR_COUNT,
    output logic [15:0]      FIRST_ERR_IDX,
    output logic [DSIZE-1:0] FIRST_ERR_DATA,
    output logic [2:0]       DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WRITE = 3'd2,
        S_DRAIN = 3'd3,
        S_RLOAD = 3'd4,
        S_READ  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    localparam logic [16:0] WORDS_X    = 17'(WORDS);
    localparam logic [15:0] LAST_IDX   = 16'(WORDS - 1);
    localparam logic [15:0] CLR_LAST   = 16'(CLR_CYC - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);
    localparam logic [31:0] WDOG_LIM   = 32'(WDOG);

    state_t           state, state_n;
    logic             start_q;
    logic             start_rise;
    logic [15:0]      wr_idx, rd_idx, chk_idx;
    logic [15:0]      phase_cnt;
    logic [15:0]      wr_use_q;
    logic [31:0]      wdog_cnt;
    logic             rd_vld;
    logic             err_seen;
    logic             wr_fire, rd_fire;
    logic             wr_load_c, rd_load_c;
    logic             wdog_hit;
    logic             active;
    logic             progress;
    logic [DSIZE-1:0] exp_data;

    assign WR_ADDR     = ASIZE'(START_ADDR);
    assign RD_ADDR     = ASIZE'(START_ADDR);
    assign WR_MAX_ADDR = ASIZE'(START_ADDR + WORDS);
    assign RD_MAX_ADDR = ASIZE'(START_ADDR + WORDS);
    assign WR_LENGTH   = 9'(BURST);
    assign RD_LENGTH   = 9'(BURST);

    assign start_rise = START && !start_q;
    assign active     = (state != S_IDLE) && (state != S_FIN);
    assign wdog_hit   = active && (wdog_cnt >= WDOG_LIM);
    assign exp_data   = DSIZE'(chk_idx) ^ PATTERN;

    // Strobes are decoded from the async-reset state register, so they drop
    // the moment RESET_N asserts.
    always_comb begin
        state_n   = state;
        wr_fire   = 1'b0;
        rd_fire   = 1'b0;
        wr_load_c = 1'b0;
        rd_load_c = 1'b0;
        case (state)
            S_IDLE: if (start_rise) state_n = S_CLEAR;
            S_CLEAR: begin
                wr_load_c = 1'b1;
                rd_load_c = 1'b1;
                if (phase_cnt == CLR_LAST) state_n = S_WRITE;
            end
            S_WRITE: begin
                wr_fire = !WR_FULL && ({1'b0, wr_idx} < WORDS_X);
                if (wr_fire && wr_idx == LAST_IDX) state_n = S_DRAIN;
            end
            S_DRAIN: if (WR_USE == 16'd0 && phase_cnt == DRAIN_LAST) state_n = S_RLOAD;
            S_RLOAD: begin
                rd_load_c = 1'b1;
                if (phase_cnt == CLR_LAST) state_n = S_READ;
            end
            S_READ: begin
                rd_fire = !RD_EMPTY && ({1'b0, rd_idx} < WORDS_X);
                if (rd_vld && chk_idx == LAST_IDX) state_n = S_FIN;
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (wdog_hit) state_n = S_FIN;
    end

    assign WR        = wr_fire;
    assign WR_DATA   = wr_fire ? (DSIZE'(wr_idx) ^ PATTERN) : '0;
    assign RD        = rd_fire;
    assign WR_LOAD   = wr_load_c;
    assign RD_LOAD   = rd_load_c;
    assign BUSY      = active;
    assign DBG_STATE = state;

    assign progress = wr_fire || rd_vld || (state_n != state) ||
                      ((state == S_DRAIN) && (WR_USE != wr_use_q));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= S_IDLE;
            start_q        <= 1'b0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            chk_idx        <= '0;
            phase_cnt      <= '0;
            wr_use_q       <= '0;
            wdog_cnt       <= '0;
            rd_vld         <= 1'b0;
            err_seen       <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            TIMEOUT        <= 1'b0;
            ERR_COUNT      <= '0;
            FIRST_ERR_IDX  <= '0;
            FIRST_ERR_DATA <= '0;
        end else begin
            state    <= state_n;
            start_q  <= START;
            rd_vld   <= rd_fire;
            wr_use_q <= WR_USE;

            // Phase counter doubles as the CLEAR/RLOAD length and the
            // consecutive-empty count in DRAIN.
            if (state_n != state)
                phase_cnt <= '0;
            else if (state == S_DRAIN && WR_USE != 16'd0)
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + 16'd1;

            if (!active || progress)
                wdog_cnt <= '0;
            else if (wdog_cnt < WDOG_LIM)
                wdog_cnt <= wdog_cnt + 32'd1;

            if (state == S_IDLE && start_rise) begin
                DONE           <= 1'b0;
                PASS           <= 1'b0;
                TIMEOUT        <= 1'b0;
                ERR_COUNT      <= '0;
                FIRST_ERR_IDX  <= '0;
                FIRST_ERR_DATA <= '0;
                err_seen       <= 1'b0;
            end

            if (state == S_CLEAR)
                wr_idx <= '0;
            else if (wr_fire)
                wr_idx <= wr_idx + 16'd1;

            if (state == S_RLOAD)
                rd_idx <= '0;
            else if (rd_fire)
                rd_idx <= rd_idx + 16'd1;

            if (state == S_RLOAD) begin
                chk_idx <= '0;
            end else if (rd_vld) begin
                chk_idx <= chk_idx + 16'd1;
                if (RD_DATA != exp_data) begin
                    if (!err_seen) begin
                        err_seen       <= 1'b1;
                        FIRST_ERR_IDX  <= chk_idx;
                        FIRST_ERR_DATA <= RD_DATA;
                    end
                    if (ERR_COUNT != 16'hFFFF) ERR_COUNT <= ERR_COUNT + 16'd1;
                end
            end

            if (wdog_hit) TIMEOUT <= 1'b1;

            if (state == S_FIN) begin
                DONE <= 1'b1;
                PASS <= (ERR_COUNT == 16'd0) && !TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_sdram_fifo_tester.sv
// Directed bench for sdram_fifo_tester against a small behavioural model of
// the controller FIFOs and SDRAM array.
module tb_sdram_fifo_tester;

    localparam int WORDS = 32;

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic        WR;
    logic [15:0] WR_DATA;
    logic        WR_FULL;
    logic [15:0] WR_USE;
    logic        WR_LOAD;
    logic        RD;
    logic [15:0] RD_DATA;
    logic        RD_EMPTY;
    logic        RD_LOAD;
    logic [22:0] WR_ADDR, RD_ADDR, WR_MAX_ADDR, RD_MAX_ADDR;
    logic [8:0]  WR_LENGTH, RD_LENGTH;
    logic        BUSY, DONE, PASS, TIMEOUT;
    logic [15:0] ERR_COUNT, FIRST_ERR_IDX, FIRST_ERR_DATA;
    logic [2:0]  DBG_STATE;

    int checks = 0;
    int errors = 0;

    sdram_fifo_tester #(
        .DSIZE(16), .ASIZE(23), .WORDS(WORDS), .BURST(8), .START_ADDR(0),
        .PATTERN(16'hA5C3), .CLR_CYC(4), .DRAIN_CYC(8), .WDOG(200)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START),
        .WR(WR), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL), .WR_USE(WR_USE), .WR_LOAD(WR_LOAD),
        .RD(RD), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY), .RD_LOAD(RD_LOAD),
        .WR_ADDR(WR_ADDR), .RD_ADDR(RD_ADDR), .WR_MAX_ADDR(WR_MAX_ADDR), .RD_MAX_ADDR(RD_MAX_ADDR),
        .WR_LENGTH(WR_LENGTH), .RD_LENGTH(RD_LENGTH),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMEOUT(TIMEOUT),
        .ERR_COUNT(ERR_COUNT), .FIRST_ERR_IDX(FIRST_ERR_IDX), .FIRST_ERR_DATA(FIRST_ERR_DATA),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- controller + SDRAM model ----------------
    logic        wr_full_force = 1'b0;
    logic        rd_empty_force = 1'b0;
    int          fault_idx = -1;
    logic [15:0] mem [0:63];
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    logic [15:0] got_q[$];
    int w_ptr = 0, r_ptr = 0, rd_pop_idx = 0;
    int w_cnt = 0, r_cnt = 0, cyc = 0;
    int wr_pulses = 0, rd_pulses = 0, wr_while_full = 0;
    int wload_cycles = 0, rload_cycles = 0, last_rload_cyc = 0;

    assign WR_FULL  = wr_full_force || (w_cnt >= 16);
    assign WR_USE   = 16'(w_cnt);
    assign RD_EMPTY = rd_empty_force || (r_cnt == 0);

    always @(posedge CLK) begin : model
        logic [15:0] d;
        cyc <= cyc + 1;
        if (WR) begin
            wr_pulses <= wr_pulses + 1;
            got_q.push_back(WR_DATA);
            if (WR_FULL) wr_while_full <= wr_while_full + 1;
        end
        if (RD) rd_pulses <= rd_pulses + 1;
        if (WR_LOAD) wload_cycles <= wload_cycles + 1;
        if (RD_LOAD) begin
            rload_cycles   <= rload_cycles + 1;
            last_rload_cyc <= cyc;
        end
        if (WR_LOAD) begin
            wq.delete();
            w_ptr = 0;
        end else begin
            if (WR) wq.push_back(WR_DATA);
            if ((cyc % 2) == 0 && wq.size() > 0) begin
                d = wq.pop_front();
                if (w_ptr < 64) mem[w_ptr] = d;
                w_ptr++;
            end
        end
        if (RD_LOAD) begin
            rq.delete();
            r_ptr = 0;
            rd_pop_idx = 0;
        end else begin
            if (RD && rq.size() > 0) begin
                d = rq.pop_front();
                if (rd_pop_idx == fault_idx) d = 16'h0000;
                RD_DATA <= d;
                rd_pop_idx++;
            end
            if (rq.size() < 8 && r_ptr < WORDS) begin
                rq.push_back(mem[r_ptr]);
                r_ptr++;
            end
        end
        w_cnt <= wq.size();
        r_cnt <= rq.size();
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        START   = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({WR, RD, WR_LOAD, RD_LOAD, BUSY, DONE, PASS, TIMEOUT} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000000", {WR, RD, WR_LOAD, RD_LOAD, BUSY, DONE, PASS, TIMEOUT});
        end
        checks++;
        if ({ERR_COUNT, FIRST_ERR_IDX, FIRST_ERR_DATA} !== 48'h0) begin
            errors++;
            $display("FAIL reset_stats got %h want 0", {ERR_COUNT, FIRST_ERR_IDX, FIRST_ERR_DATA});
        end
        checks++;
        if (WR_MAX_ADDR !== 23'd32 || RD_MAX_ADDR !== 23'd32 || WR_ADDR !== 23'd0 || RD_ADDR !== 23'd0) begin
            errors++;
            $display("FAIL reset_addr got wmax %0d rmax %0d wa %0d ra %0d want 32 32 0 0",
                     WR_MAX_ADDR, RD_MAX_ADDR, WR_ADDR, RD_ADDR);
        end
        checks++;
        if (WR_LENGTH !== 9'd8 || RD_LENGTH !== 9'd8) begin
            errors++;
            $display("FAIL reset_len got %0d %0d want 8 8", WR_LENGTH, RD_LENGTH);
        end
        @(negedge CLK) RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_normal();
        logic [15:0] exp_q[$];
        int wb, rb, wlb, rlb, gb, bad;
        bit ok;
        wb = wr_pulses; rb = rd_pulses; wlb = wload_cycles; rlb = rload_cycles; gb = got_q.size();
        pulse_start();
        wait_done(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL normal_done got DONE %b want 1 within budget", DONE);
        end
        for (int i = 0; i < WORDS; i++) exp_q.push_back(16'(i) ^ 16'hA5C3);
        checks++;
        if (got_q[gb] !== 16'hA5C3 || got_q[gb+1] !== 16'hA5C2) begin
            errors++;
            $display("FAIL normal_first_words got %h %h want a5c3 a5c2", got_q[gb], got_q[gb+1]);
        end
        bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (got_q[gb+i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL normal_wr_data got %0d bad words want 0", bad);
        end
        checks++;
        if (wr_pulses - wb != WORDS || rd_pulses - rb != WORDS) begin
            errors++;
            $display("FAIL normal_counts got wr %0d rd %0d want 32 32", wr_pulses - wb, rd_pulses - rb);
        end
        checks++;
        if (wload_cycles - wlb != 4 || rload_cycles - rlb != 8) begin
            errors++;
            $display("FAIL normal_load_cycles got wr_load %0d rd_load %0d want 4 8",
                     wload_cycles - wlb, rload_cycles - rlb);
        end
        checks++;
        if (PASS !== 1'b1 || ERR_COUNT !== 16'd0 || TIMEOUT !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL normal_result got pass %b err %0d to %b busy %b want 1 0 0 0", PASS, ERR_COUNT, TIMEOUT, BUSY);
        end
    endtask

    task automatic test_fault();
        bit ok;
        fault_idx = 20;
        pulse_start();
        wait_done(2000, ok);
        fault_idx = -1;
        checks++;
        if (!ok || ERR_COUNT !== 16'd1 || PASS !== 1'b0) begin
            errors++;
            $display("FAIL fault_result got done %b err %0d pass %b want 1 1 0", DONE, ERR_COUNT, PASS);
        end
        checks++;
        if (FIRST_ERR_IDX !== 16'd20 || FIRST_ERR_DATA !== 16'h0000) begin
            errors++;
            $display("FAIL fault_first got idx %0d data %h want 20 0000", FIRST_ERR_IDX, FIRST_ERR_DATA);
        end
    endtask

    task automatic test_back_to_back();
        int wb, wlb;
        bit ok;
        wb = wr_pulses; wlb = wload_cycles;
        pulse_start();
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0 || ERR_COUNT !== 16'd0 || PASS !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear got busy %b done %b err %0d pass %b want 1 0 0 0", BUSY, DONE, ERR_COUNT, PASS);
        end
        repeat (10) @(negedge CLK);
        pulse_start();
        wait_done(2000, ok);
        checks++;
        if (!ok || PASS !== 1'b1 || ERR_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL restart_result got done %b pass %b err %0d want 1 1 0", DONE, PASS, ERR_COUNT);
        end
        checks++;
        if (wload_cycles - wlb != 4 || wr_pulses - wb != WORDS) begin
            errors++;
            $display("FAIL busy_start_ignored got wr_load %0d wr %0d want 4 32", wload_cycles - wlb, wr_pulses - wb);
        end
        repeat (5) @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_hold got done %b busy %b want 1 0", DONE, BUSY);
        end
    endtask

    task automatic test_wr_full();
        int wb, p0, wf0;
        bit ok, hit;
        wb = wr_pulses; wf0 = wr_while_full; hit = 1'b0;
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (wr_pulses - wb >= 10) begin
                hit = 1'b1;
                break;
            end
        end
        wr_full_force = 1'b1;
        p0 = wr_pulses;
        repeat (50) @(negedge CLK);
        checks++;
        if (!hit || wr_pulses != p0) begin
            errors++;
            $display("FAIL full_hold got reached %b writes_while_forced %0d want 1 0", hit, wr_pulses - p0);
        end
        wr_full_force = 1'b0;
        wait_done(2000, ok);
        checks++;
        if (!ok || wr_pulses - wb != WORDS || PASS !== 1'b1) begin
            errors++;
            $display("FAIL full_result got done %b wr %0d pass %b want 1 32 1", DONE, wr_pulses - wb, PASS);
        end
        checks++;
        if (wr_while_full != wf0) begin
            errors++;
            $display("FAIL wr_while_full got %0d want 0", wr_while_full - wf0);
        end
    endtask

    task automatic test_timeout();
        int dt;
        bit ok;
        rd_empty_force = 1'b1;
        pulse_start();
        wait_done(3000, ok);
        dt = cyc - last_rload_cyc;
        rd_empty_force = 1'b0;
        checks++;
        if (!ok || TIMEOUT !== 1'b1 || PASS !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result got done %b timeout %b pass %b want 1 1 0", DONE, TIMEOUT, PASS);
        end
        checks++;
        if (dt < 198 || dt > 210) begin
            errors++;
            $display("FAIL timeout_latency got %0d cycles want 198..210", dt);
        end
    endtask

    task automatic test_reset_mid();
        int wb;
        bit ok, hit;
        wb = wr_pulses; hit = 1'b0;
        pulse_start();
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (WR && (wr_pulses - wb >= 12)) begin
                hit = 1'b1;
                break;
            end
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if (!hit || {WR, RD, WR_LOAD, RD_LOAD, BUSY} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid got reached %b strobes %b want 1 00000", hit, {WR, RD, WR_LOAD, RD_LOAD, BUSY});
        end
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        wb = wr_pulses;
        pulse_start();
        wait_done(2000, ok);
        checks++;
        if (!ok || PASS !== 1'b1 || wr_pulses - wb != WORDS) begin
            errors++;
            $display("FAIL reset_mid_rerun got done %b pass %b wr %0d want 1 1 32", DONE, PASS, wr_pulses - wb);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_normal();
        test_fault();
        test_back_to_back();
        test_wr_full();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_fifo_tester.md
Name: sdram_fifo_tester

Overview:
Host-side traffic generator and checker for the SDRAM controller's FIFO write and read ports. It sits on the opposite side of those ports from the controller. It clears both FIFOs, streams a deterministic pattern of WORDS words into the write FIFO, and waits for the controller to drain that data to SDRAM. It then restarts the read side, pulls WORDS words back from the read FIFO, compares each word against the expected pattern, and reports pass/fail plus error statistics. It runs single-clock: integration ties the controller's WR_CLK and RD_CLK to this block's CLK.

Parameters:
DSIZE, 16, FIFO data width
ASIZE, 23, SDRAM word address width
WORDS, 1024, words per test run; must be a nonzero multiple of BURST
BURST, 256, driven onto WR_LENGTH/RD_LENGTH; range 1..256
START_ADDR, 0, first SDRAM word address
PATTERN, 16'hA5C3, XOR key; expected word = idx[DSIZE-1:0] ^ PATTERN
CLR_CYC, 4, cycles WR_LOAD/RD_LOAD are held high per clear
DRAIN_CYC, 64, quiet cycles required after write FIFO empties before the read phase
WDOG, 65535, cycles without progress before timeout

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
START  in  1  rising edge starts a run (ignored unless IDLE or DONE)
WR  out  1  write-FIFO write request
WR_DATA  out  DSIZE  write-FIFO data
WR_FULL  in  1  write-FIFO full
WR_USE  in  16  write-FIFO used words
WR_LOAD  out  1  write address load / FIFO clear
RD  out  1  read-FIFO read request
RD_DATA  in  DSIZE  read-FIFO data (normal mode, valid 1 cycle after RD)
RD_EMPTY  in  1  read-FIFO empty
RD_LOAD  out  1  read address load / FIFO clear
WR_ADDR, RD_ADDR  out  ASIZE  constant START_ADDR
WR_MAX_ADDR, RD_MAX_ADDR  out  ASIZE  constant START_ADDR+WORDS
WR_LENGTH, RD_LENGTH  out  9  constant BURST
BUSY  out  1  run in progress
DONE  out  1  run finished, held until next START
PASS  out  1  valid with DONE: zero errors and no timeout
TIMEOUT  out  1  watchdog fired
ERR_COUNT  out  16  mismatches, saturating at 16'hFFFF
FIRST_ERR_IDX  out  16  word index of first mismatch
FIRST_ERR_DATA  out  DSIZE  data received at first mismatch

Behaviour:
- Reset values: all outputs 0 except the constant address/length ports. State = IDLE. Indexes and counters = 0.
- Reset mid-run: abort immediately. WR, RD, WR_LOAD and RD_LOAD drop asynchronously. The controller reset handles its own side.
- START edge detect: start_q registered. Acceptance happens in the cycle after START rises. Accepting clears ERR_COUNT, FIRST_ERR_*, DONE, PASS and TIMEOUT, sets BUSY=1 and enters CLEAR.
- CLEAR: WR_LOAD=RD_LOAD=1 for exactly CLR_CYC cycles. Then go to WRITE with wr_idx=0.
- WRITE: WR=1 and WR_DATA=wr_idx^PATTERN in any cycle with WR_FULL=0 and wr_idx<WORDS. wr_idx increments on each WR cycle. WR is combinationally gated by WR_FULL, so no write is issued while full. When wr_idx reaches WORDS, go to DRAIN.
- DRAIN: wait for WR_USE==0, then count DRAIN_CYC consecutive cycles with WR_USE==0. Any nonzero WR_USE restarts the count. Then go to RLOAD. The controller may have filled the read FIFO with stale data during WRITE; that data is discarded in RLOAD.
- RLOAD: RD_LOAD=1 for CLR_CYC cycles, which clears the read FIFO and resets the read address. Then go to READ with rd_idx=0 and chk_idx=0.
- READ: RD=1 when RD_EMPTY=0 and the issued count < WORDS. A 1-cycle delayed strobe marks RD_DATA valid.
  - On a valid strobe, compare RD_DATA to chk_idx^PATTERN, then increment chk_idx.
  - On the first mismatch, latch FIRST_ERR_IDX=chk_idx and FIRST_ERR_DATA=RD_DATA.
  - Every mismatch increments ERR_COUNT, saturating at 16'hFFFF.
  - When chk_idx reaches WORDS, go to FIN.
- FIN: BUSY=0, DONE=1, PASS=(ERR_COUNT==0)&&!TIMEOUT. Return to IDLE behaviour: wait for START.
- Watchdog: a cycle counter clears on any WR, any valid read strobe, any WR_USE change in DRAIN, or any state change. If it reaches WDOG, set TIMEOUT=1 and go to FIN.
- Width rules: indexes are 16 bits wide. The pattern uses idx[DSIZE-1:0]. The WR_MAX_ADDR add is truncated to ASIZE.
- START pulses while BUSY are ignored.

Test Plan:
- Reset, then pulse START with WORDS=1024 and BURST=256 against the controller plus SDRAM model -> WR_LOAD/RD_LOAD high for 4 cycles; 1024 WR pulses; first word 16'hA5C3, word 1 16'hA5C2; DONE=1, PASS=1, ERR_COUNT=0.
- Fault injection: read word 300 returns 16'h0000 -> ERR_COUNT=1, FIRST_ERR_IDX=300, FIRST_ERR_DATA=0, PASS=0.
- WR_FULL forced high for 50 cycles mid-WRITE -> no WR while full; total WR count stays exactly 1024; PASS=1.
- RD_EMPTY stuck high in READ with WDOG=1000 -> TIMEOUT=1 about 1000 cycles later; DONE=1, PASS=0.
- RESET_N asserted during WRITE at wr_idx=500 -> all strobes 0 in the same cycle, BUSY=0; after release, START runs a full pass.
- START re-pulsed while BUSY -> ignored; a second START after DONE clears the stats and reruns.
